parity_run_arbiter: RTL and testbench



---
 rtl/parity_run_arbiter.sv | 145 ++++++++++++++
 tb/tb_parity_run_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_run_arbiter.sv
// Round-robin shared parity-run detector with a per-requester run-length context.
// Define PRS_HITCNT_EN to build the per-requester saturating hit counters.
module parity_run_arbiter #(
   parameter int NREQ    = 4,
   parameter int RUN_LEN = 3,
   parameter int IDW     = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [3*NREQ-1:0]   req_w,
   output logic [NREQ-1:0]     req_ready,
   input  logic                ctx_clr,
   output logic                det_valid,
   output logic [IDW-1:0]      det_ch,
   output logic                det_k,
   output logic                det_z,
   output logic                busy,
   input  logic [IDW-1:0]      hit_sel,
   output logic [7:0]          hit_cnt
);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t         state, state_nx;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant_idx;
   logic           grant_found;
   logic           hs;
   logic [2:0]     sel_w;
   logic [3:0]     cnt [NREQ];
   logic [3:0]     cnt_cur;
   logic [3:0]     cnt_new;
   logic           k_new;
   logic           z_new;

   // Valid/ready: a requester holds req_valid and its word until req_ready is seen
   // high with it at a clock edge; that edge completes the handshake.

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ctx_clr) state_nx = CLEAR;
         CLEAR:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == CLEAR);

   // Search starts one past the last completed grant, wrapping at NREQ.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = int'(last_grant) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_found && req_valid[idx[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (!reset && state == IDLE && !ctx_clr && grant_found)
         req_ready[grant_idx] = 1'b1;
   end

   assign hs = |(req_valid & req_ready);

   always_comb begin
      sel_w   = 3'b000;
      cnt_cur = 4'd0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            sel_w   = req_w[3*i +: 3];
            cnt_cur = cnt[i];
         end
      end
   end

   assign k_new   = ^sel_w;
   assign cnt_new = !k_new ? 4'd0 :
                    (cnt_cur >= 4'(RUN_LEN)) ? 4'(RUN_LEN) : cnt_cur + 4'd1;
   assign z_new   = (cnt_new == 4'(RUN_LEN));

   always_ff @(posedge clk) begin
      if (reset) begin
         det_valid  <= 1'b0;
         det_ch     <= '0;
         det_k      <= 1'b0;
         det_z      <= 1'b0;
         last_grant <= IDW'(NREQ - 1);
         for (int i = 0; i < NREQ; i++) cnt[i] <= 4'd0;
      end else begin
         det_valid <= hs;
         if (hs) begin
            det_ch     <= grant_idx;
            det_k      <= k_new;
            det_z      <= z_new;
            last_grant <= grant_idx;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (state == CLEAR)
               cnt[i] <= 4'd0;
            else if (hs && grant_idx == IDW'(i))
               cnt[i] <= cnt_new;
         end
      end
   end

`ifdef PRS_HITCNT_EN
   logic [7:0] hits [NREQ];

   // Counted at the handshake edge so the count is visible alongside det_z.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) hits[i] <= 8'd0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (state == CLEAR)
               hits[i] <= 8'd0;
            else if (hs && z_new && grant_idx == IDW'(i) && hits[i] != 8'hff)
               hits[i] <= hits[i] + 8'd1;
         end
      end
   end

   assign hit_cnt = hits[hit_sel];
`else
   logic unused_hit_sel;
   assign unused_hit_sel = ^hit_sel;
   assign hit_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_parity_run_arbiter.sv
// Self-checking bench for parity_run_arbiter: per-cycle reference model feeding an expected queue.
module tb_parity_run_arbiter;
   localparam int NREQ    = 4;
   localparam int RUN_LEN = 3;
   localparam int IDW     = 2;
   localparam int W       = IDW + 3;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [3*NREQ-1:0]   req_w;
   logic [NREQ-1:0]     req_ready;
   logic                ctx_clr;
   logic                det_valid;
   logic [IDW-1:0]      det_ch;
   logic                det_k;
   logic                det_z;
   logic                busy;
   logic [IDW-1:0]      hit_sel;
   logic [7:0]          hit_cnt;

   int          checks;
   int          errors;
   logic [W-1:0] exp_q[$];
   int          m_cnt  [NREQ];
   int          m_hits [NREQ];
   int          m_lg;
   bit          m_clear;
   logic [W-1:0] m_last;

   parity_run_arbiter #(.NREQ(NREQ), .RUN_LEN(RUN_LEN), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_w     (req_w),
      .req_ready (req_ready),
      .ctx_clr   (ctx_clr),
      .det_valid (det_valid),
      .det_ch    (det_ch),
      .det_k     (det_k),
      .det_z     (det_z),
      .busy      (busy),
      .hit_sel   (hit_sel),
      .hit_cnt   (hit_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_lg    = NREQ - 1;
      m_clear = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         m_cnt[i]  = 0;
         m_hits[i] = 0;
      end
      m_last = '0;
      exp_q.delete();
      exp_q.push_back('0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '1;
      req_w     = '0;
      ctx_clr   = 1'b0;
      @(negedge clk);
      check_val("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = '0;
      model_reset();
   endtask

   function automatic logic [3*NREQ-1:0] w_at(input int i, input logic [2:0] w);
      logic [3*NREQ-1:0] v;
      v = 3*NREQ'($urandom);
      v[3*i +: 3] = w;
      return v;
   endfunction

   // Drive one cycle, compare outputs at the falling edge, then advance the model.
   task automatic step(input logic [NREQ-1:0] rv, input logic [3*NREQ-1:0] rw, input logic clr);
      logic [NREQ-1:0] exp_rdy;
      logic [W-1:0]    e;
      logic [2:0]      w;
      logic            k;
      int              g;
      int              n;
      int              idx;
      req_valid = rv;
      req_w     = rw;
      ctx_clr   = clr;
      hit_sel   = IDW'($urandom_range(0, NREQ - 1));
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check_val("exp_q_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_val("det_valid", 32'(det_valid), 32'(e[W-1]));
         check_val("det_ch",    32'(det_ch),    32'(e[W-2:2]));
         check_val("det_k",     32'(det_k),     32'(e[1]));
         check_val("det_z",     32'(det_z),     32'(e[0]));
      end
      check_val("busy", 32'(busy), 32'(m_clear));
`ifdef PRS_HITCNT_EN
      check_val("hit_cnt", 32'(hit_cnt), 32'(m_hits[hit_sel]));
`else
      check_val("hit_cnt", 32'(hit_cnt), 32'd0);
`endif
      exp_rdy = '0;
      g = -1;
      if (!m_clear && !clr) begin
         for (int off = 1; off <= NREQ; off++) begin
            idx = (m_lg + off) % NREQ;
            if (g < 0 && rv[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_clear) begin
         for (int i = 0; i < NREQ; i++) begin
            m_cnt[i]  = 0;
            m_hits[i] = 0;
         end
         m_clear = 1'b0;
      end else if (clr) begin
         m_clear = 1'b1;
      end
      if (g >= 0) begin
         w = rw[3*g +: 3];
         k = w[0] ^ w[1] ^ w[2];
         n = k ? ((m_cnt[g] + 1 > RUN_LEN) ? RUN_LEN : m_cnt[g] + 1) : 0;
         m_cnt[g] = n;
         if (n == RUN_LEN && m_hits[g] < 255) m_hits[g]++;
         m_last = {1'b1, IDW'(g), k, (n == RUN_LEN)};
         m_lg   = g;
      end else begin
         m_last[W-1] = 1'b0;
      end
      exp_q.push_back(m_last);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      hit_sel   = '0;
      req_valid = '0;
      req_w     = '0;
      ctx_clr   = 1'b0;
      reset     = 1'b1;

      // requester 1 alone, three odd-parity words: z on the third
      do_reset();
      repeat (3) step(4'b0010, w_at(1, 3'b001), 1'b0);
      step('0, '0, 1'b0);

      // all requesters pending: strict rotation
      do_reset();
      repeat (8) step(4'b1111, 3*NREQ'($urandom), 1'b0);
      step('0, '0, 1'b0);

      // requester 2: k=1,1,0,1, never reaching the run
      do_reset();
      step(4'b0100, w_at(2, 3'b111), 1'b0);
      step(4'b0100, w_at(2, 3'b111), 1'b0);
      step(4'b0100, w_at(2, 3'b011), 1'b0);
      step(4'b0100, w_at(2, 3'b100), 1'b0);
      step('0, '0, 1'b0);

      // interleaved contexts: requester 3's k=0 must not break requester 0's run
      do_reset();
      step(4'b0001, w_at(0, 3'b010), 1'b0);
      step(4'b1000, w_at(3, 3'b110), 1'b0);
      step(4'b0001, w_at(0, 3'b100), 1'b0);
      step(4'b0001, w_at(0, 3'b111), 1'b0);
      step('0, '0, 1'b0);

      // ctx_clr with pending requests after requester 0 reached 2
      do_reset();
      step(4'b0001, w_at(0, 3'b001), 1'b0);
      step(4'b0001, w_at(0, 3'b001), 1'b0);
      step(4'b0001, w_at(0, 3'b001), 1'b1);
      step(4'b0001, w_at(0, 3'b001), 1'b1);
      step(4'b0001, w_at(0, 3'b001), 1'b0);
      step('0, '0, 1'b0);

      // reset right after a handshake drops the result and restores priority to 0
      step(4'b0100, w_at(2, 3'b001), 1'b0);
      do_reset();
      step(4'b1111, 3*NREQ'($urandom), 1'b0);
      step('0, '0, 1'b0);

      // random traffic with occasional clears
      for (int i = 0; i < 80; i++) begin
         step(NREQ'($urandom_range(0, 15)), 3*NREQ'($urandom), ($urandom_range(0, 9) == 0));
      end
      step('0, '0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
